// File: rtl/execute_pkg.sv
// Shared pipeline definitions: op codes and the multiplier FSM state encoding.
package execute_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 5;
  localparam int unsigned MUL_ITERS = 32;

  localparam logic [OP_W-1:0] OP_ADD   = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 5'd1;
  localparam logic [OP_W-1:0] OP_AND   = 5'd2;
  localparam logic [OP_W-1:0] OP_OR    = 5'd3;
  localparam logic [OP_W-1:0] OP_XOR   = 5'd4;
  localparam logic [OP_W-1:0] OP_SLL   = 5'd5;
  localparam logic [OP_W-1:0] OP_SRL   = 5'd6;
  localparam logic [OP_W-1:0] OP_SRA   = 5'd7;
  localparam logic [OP_W-1:0] OP_SLT   = 5'd8;
  localparam logic [OP_W-1:0] OP_SLTU  = 5'd9;
  localparam logic [OP_W-1:0] OP_BEQ   = 5'd10;
  localparam logic [OP_W-1:0] OP_BNE   = 5'd11;
  localparam logic [OP_W-1:0] OP_BLT   = 5'd12;
  localparam logic [OP_W-1:0] OP_BGE   = 5'd13;
  localparam logic [OP_W-1:0] OP_BLTU  = 5'd14;
  localparam logic [OP_W-1:0] OP_BGEU  = 5'd15;
  localparam logic [OP_W-1:0] OP_MUL   = 5'd16;
  localparam logic [OP_W-1:0] OP_MULHU = 5'd17;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/execute_if.sv
// Execute-stage bus: instruction in from register access, result and redirect out.
interface execute_if;
  import execute_pkg::*;

  logic            valid_input;
  logic            ready_output;
  logic [XLEN-1:0] data_a;
  logic [XLEN-1:0] data_b;
  logic [OP_W-1:0] execute_instruction_input;
  logic            condition_branch_input;
  logic            taken_input;
  logic [XLEN-1:0] pc_input;
  logic [XLEN-1:0] immediate_value_input;
  logic            valid_output;
  logic [XLEN-1:0] result;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_output;

  // Upstream / bench side
  modport master (
    output valid_input, data_a, data_b, execute_instruction_input,
           condition_branch_input, taken_input, pc_input, immediate_value_input,
    input  ready_output, valid_output, result, redirect_valid, redirect_pc, flush_output
  );

  // Execute stage side
  modport slave (
    input  valid_input, data_a, data_b, execute_instruction_input,
           condition_branch_input, taken_input, pc_input, immediate_value_input,
    output ready_output, valid_output, result, redirect_valid, redirect_pc, flush_output
  );
endinterface

// File: rtl/execute_shift_add_multiplier.sv
// Iterative unsigned 32x32 multiplier: one shift-add step per clock, 32 steps.
module shift_add_multiplier
  import execute_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic              o_done,
  output logic [2*XLEN-1:0] o_product
);

  logic              r_busy;
  logic [4:0]        r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [2*XLEN-1:0] w_sum;

  // Partial sum including the current step; on the last step it is the full product,
  // so done and product are valid in the same cycle the final step is taken.
  always_comb begin
    w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
  end

  assign o_done    = r_busy && (r_cnt == 5'd31);
  assign o_product = w_sum;

  // Load operands on start, then shift multiplicand left / multiplier right each step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{XLEN{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_busy) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/execute.sv
// Execute stage: single-cycle ALU, branch resolution with redirect, iterative MUL/MULHU.
module execute
  import execute_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  execute_if.slave bus
);

  mul_state_t        r_state, w_next;
  logic              w_ready;
  logic              w_accept;
  logic              w_mul_start;
  logic              w_mul_done;
  logic [2*XLEN-1:0] w_product;
  logic [XLEN-1:0]   w_alu;
  logic              w_taken;
  logic              w_mispredict;
  logic [XLEN-1:0]   w_target;
  logic [XLEN-1:0]   w_a, w_b;
  logic [4:0]        w_shamt;
  logic [OP_W-1:0]   w_op;

  logic              r_valid;
  logic [XLEN-1:0]   r_result;
  logic              r_redirect;
  logic [XLEN-1:0]   r_redirect_pc;
  logic              r_mul_hi;

  assign w_a     = bus.data_a;
  assign w_b     = bus.data_b;
  assign w_shamt = bus.data_b[4:0];
  assign w_op    = bus.execute_instruction_input;

  // valid_input is ignored while BUSY because ready is low
  assign w_accept    = bus.valid_input && w_ready;
  assign w_mul_start = w_accept && is_mul_op(w_op);

  shift_add_multiplier u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // FSM next state: enter BUSY on a multiply accept, leave on the final step
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_mul_start) w_next = BUSY;
      BUSY:    if (w_mul_done)  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs: stall upstream while the multiplier is iterating
  always_comb begin
    w_ready = (r_state == IDLE);
  end

  // Single-cycle ALU; branches and unassigned codes produce zero
  always_comb begin
    w_alu = '0;
    if (!bus.condition_branch_input) begin
      case (w_op)
        OP_ADD:  w_alu = w_a + w_b;
        OP_SUB:  w_alu = w_a - w_b;
        OP_AND:  w_alu = w_a & w_b;
        OP_OR:   w_alu = w_a | w_b;
        OP_XOR:  w_alu = w_a ^ w_b;
        OP_SLL:  w_alu = w_a << w_shamt;
        OP_SRL:  w_alu = w_a >> w_shamt;
        OP_SRA:  w_alu = $unsigned($signed(w_a) >>> w_shamt);
        OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
        OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (w_a < w_b)};
        default: w_alu = '0;
      endcase
    end
  end

  // Branch resolution: actual direction, misprediction, and corrected fetch target
  always_comb begin
    w_taken = 1'b0;
    case (w_op)
      OP_BEQ:  w_taken = (w_a == w_b);
      OP_BNE:  w_taken = (w_a != w_b);
      OP_BLT:  w_taken = ($signed(w_a) <  $signed(w_b));
      OP_BGE:  w_taken = ($signed(w_a) >= $signed(w_b));
      OP_BLTU: w_taken = (w_a <  w_b);
      OP_BGEU: w_taken = (w_a >= w_b);
      default: w_taken = 1'b0;
    endcase
    w_mispredict = bus.condition_branch_input && (w_taken != bus.taken_input);
    w_target     = w_taken ? (bus.pc_input + bus.immediate_value_input)
                           : (bus.pc_input + 32'd4);
  end

  // Registered outputs: pulses self-clear, data held until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= 1'b0;
      r_result      <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_mul_hi      <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_redirect <= 1'b0;
      if (w_mul_start) begin
        r_mul_hi <= (w_op == OP_MULHU);
      end else if (w_accept) begin
        r_valid  <= 1'b1;
        r_result <= w_alu;
        if (w_mispredict) begin
          r_redirect    <= 1'b1;
          r_redirect_pc <= w_target;
        end
      end else if ((r_state == BUSY) && w_mul_done) begin
        r_valid  <= 1'b1;
        r_result <= r_mul_hi ? w_product[2*XLEN-1:XLEN] : w_product[XLEN-1:0];
      end
    end
  end

  assign bus.ready_output   = w_ready;
  assign bus.valid_output   = r_valid;
  assign bus.result         = r_result;
  assign bus.redirect_valid = r_redirect;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.flush_output   = r_redirect;

endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage with an expected-result scoreboard.
module tb_execute;
  import execute_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  execute_if u_if();

  execute u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  typedef struct {
    logic [31:0] res;
    logic        redir;
    logic [31:0] rpc;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t q[$];
  int n_pass = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Scoreboard: every completed instruction must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (u_if.valid_output) begin
        assert (q.size() != 0) n_pass++;
        else begin
          n_fail++;
          $error("FAIL spurious_valid got result=%h want no valid_output", u_if.result);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          chk({e.tag, ".result"}, u_if.result, e.res);
          chk({e.tag, ".cycle"}, cyc, e.cyc);
          chk({e.tag, ".redirect"}, {31'b0, u_if.redirect_valid}, {31'b0, e.redir});
          chk({e.tag, ".flush"}, {31'b0, u_if.flush_output}, {31'b0, e.redir});
          if (e.redir) chk({e.tag, ".redirect_pc"}, u_if.redirect_pc, e.rpc);
        end
      end else begin
        chk("redirect_without_valid", {31'b0, u_if.redirect_valid}, 32'd0);
      end
    end
  end

  // Present one instruction, wait for accept, record expectation; d = extra edges after accept
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic cb, input logic tk, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] xres, input logic xredir, input logic [31:0] xrpc,
                      input int d, input string tag, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    u_if.execute_instruction_input = op;
    u_if.data_a = a;
    u_if.data_b = b;
    u_if.condition_branch_input = cb;
    u_if.taken_input = tk;
    u_if.pc_input = pc;
    u_if.immediate_value_input = imm;
    u_if.valid_input = 1'b1;
    while (!u_if.ready_output && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".accept_ready"}, {31'b0, u_if.ready_output}, 32'd1);
    acc = cyc + 1;
    q.push_back('{xres, xredir, xrpc, acc + d, tag});
    @(posedge clk);
    #1 u_if.valid_input = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", q.size(), 32'd0);
  endtask

  initial begin
    int acc, acc_mul, acc_add;
    u_if.valid_input = 1'b0;
    u_if.execute_instruction_input = '0;
    u_if.data_a = '0;
    u_if.data_b = '0;
    u_if.condition_branch_input = 1'b0;
    u_if.taken_input = 1'b0;
    u_if.pc_input = '0;
    u_if.immediate_value_input = '0;

    // Reset state
    #2;
    chk("rst.ready", {31'b0, u_if.ready_output}, 32'd1);
    chk("rst.valid", {31'b0, u_if.valid_output}, 32'd0);
    chk("rst.result", u_if.result, 32'd0);
    chk("rst.redirect", {31'b0, u_if.redirect_valid}, 32'd0);
    chk("rst.redirect_pc", u_if.redirect_pc, 32'd0);
    chk("rst.flush", {31'b0, u_if.flush_output}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle ALU ops
    send(OP_ADD,  32'hFFFFFFFF, 32'h1,        0, 0, 0, 0, 32'h00000000, 0, 0, 0, "add_wrap", acc);
    send(OP_SUB,  32'h5,        32'h7,        0, 0, 0, 0, 32'hFFFFFFFE, 0, 0, 0, "sub_neg", acc);
    send(OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 0, 0, 32'h00F000F0, 0, 0, 0, "and", acc);
    send(OP_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 0, 0, 32'hFFF0FFF0, 0, 0, 0, "or", acc);
    send(OP_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 0, 0, 32'hFF00FF00, 0, 0, 0, "xor", acc);
    send(OP_SLL,  32'h1,        32'h23,       0, 0, 0, 0, 32'h00000008, 0, 0, 0, "sll_mask", acc);
    send(OP_SRL,  32'h80000000, 32'h4,        0, 0, 0, 0, 32'h08000000, 0, 0, 0, "srl", acc);
    send(OP_SRA,  32'h80000000, 32'h21,       0, 0, 0, 0, 32'hC0000000, 0, 0, 0, "sra_mask", acc);
    send(OP_SLT,  32'hFFFFFFFF, 32'h1,        0, 0, 0, 0, 32'h00000001, 0, 0, 0, "slt", acc);
    send(OP_SLTU, 32'hFFFFFFFF, 32'h1,        0, 0, 0, 0, 32'h00000000, 0, 0, 0, "sltu", acc);
    send(5'd20,   32'h12345678, 32'h1,        0, 0, 0, 0, 32'h00000000, 0, 0, 0, "unassigned", acc);

    // Branches
    send(OP_BLT,  32'hFFFFFFFF, 32'h1, 1, 0, 32'h100, 32'h20, 32'h0, 1, 32'h120, 0, "blt_mispred", acc);
    send(OP_BLT,  32'hFFFFFFFF, 32'h1, 1, 1, 32'h100, 32'h20, 32'h0, 0, 32'h0,   0, "blt_correct", acc);
    send(OP_BNE,  32'h3,        32'h3, 1, 1, 32'h200, 32'h40, 32'h0, 1, 32'h204, 0, "bne_fallthru", acc);
    send(OP_BGEU, 32'h1, 32'hFFFFFFFF, 1, 0, 32'h300, 32'h10, 32'h0, 0, 32'h0,   0, "bgeu_nt", acc);
    send(OP_BEQ,  32'h9,        32'h9, 0, 0, 32'h400, 32'h10, 32'h0, 0, 32'h0,   0, "beq_nocond", acc);
    drain();

    // MULHU: ready low for all 32 edges, result on the 32nd
    send(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 32'hFFFFFFFE, 0, 0, 32, "mulhu", acc);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk($sformatf("mulhu.busy_ready[%0d]", i), {31'b0, u_if.ready_output}, 32'd0);
    end
    drain();

    // MUL immediately followed by a pending ADD
    send(OP_MUL, 32'd7,  32'd6,  0, 0, 0, 0, 32'd42, 0, 0, 32, "mul_7x6", acc_mul);
    send(OP_ADD, 32'd10, 32'd20, 0, 0, 0, 0, 32'd30, 0, 0, 0,  "add_after_mul", acc_add);
    chk("add_after_mul.accept_edge", acc_add, acc_mul + 33);
    drain();

    // Reset mid-multiply discards the operation
    send(OP_MUL, 32'd5, 32'd5, 0, 0, 0, 0, 32'd25, 0, 0, 32, "mul_aborted", acc);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.ready", {31'b0, u_if.ready_output}, 32'd1);
    chk("midrst.valid", {31'b0, u_if.valid_output}, 32'd0);
    chk("midrst.result", u_if.result, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("postrst.ready", {31'b0, u_if.ready_output}, 32'd1);
    chk("postrst.no_pending", q.size(), 32'd0);
    send(OP_ADD, 32'd2, 32'd3, 0, 0, 0, 0, 32'd5, 0, 0, 0, "add_after_rst", acc);
    drain();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
